nibble_serial_addsub: RTL and testbench
=======================================

Name: nibble_serial_addsub

Overview:
- Sequencer sitting directly upstream of the 4-bit adder/subtractor slice.
- Accepts WIDTH-bit add/sub requests over a valid/ready handshake.
- Feeds the operands through one 4-bit slice, one nibble per cycle, LSB first, chaining the carry in a register.
- Presents the registered result and flags downstream on a valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, number of slice cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
- out_cout  output  1  final carry out; for subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE, nibble counter = 0, carry = 0, operand registers = 0. Output reset values: out_valid 0, out_result 0, out_cout 0, out_ovf 0, out_zero 0, busy 0, in_ready 1.
- Reset asserted mid-operation aborts the operation. No result is produced and out_valid never rises for it.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready at edge T:
    - latch in_a, in_b, in_sub;
    - carry register = in_sub;
    - counter = 0;
    - go to EXEC.
  - EXEC: in_ready = 0; in_valid is ignored and nothing is latched. On each edge, nibble k = counter:
    - a_n = A[4k+3:4k];
    - b_n = B[4k+3:4k] XOR {4{sub}};
    - {c, s} = a_n + b_n + carry;
    - result[4k+3:4k] <= s; carry <= c; counter <= counter + 1.
    - On the edge processing k = NIB-1, also capture the flags and go to DONE.
  - Flags:
    - out_cout = final carry.
    - out_ovf = carry-into-MSB XOR carry-out-of-MSB, taken from the top slice.
    - out_zero = (full result == 0), evaluated on the final nibble written.
  - DONE: out_valid = 1. out_result and flags are held stable while out_ready = 0. On out_valid && out_ready, go to IDLE and drop out_valid the next cycle.
- Latency and throughput:
  - out_valid rises after edge T+NIB, i.e. NIB cycles after the accept edge.
  - No overlap between requests. A new request can be accepted at the earliest one cycle after the result handshake. Throughput is one operation per NIB+2 cycles when out_ready is held high.
- WIDTH = 4: a single EXEC cycle; same FSM, no special case.
- Outputs are registered except in_ready and busy, which are decoded directly from the state register.
- Counter width is clog2(NIB), minimum 1. The counter never wraps within an operation because DONE is entered at NIB-1.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is accepted in IDLE on a later cycle.
- Partial result nibbles written during EXEC are internal until DONE. out_result visibly changes only when DONE is entered.

Decomposition:
- Shared package addsub_pkg holds:
  - SLICE_W = 4;
  - FSM state encoding (IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2);
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
- One combinational sub-module, nibble_addsub_slice:
  - inputs a[3:0], b[3:0], sub, cin;
  - outputs s[3:0], cout, c_msb (carry into bit 3);
  - B inversion is done inside the slice.
- This block instantiates exactly one slice and muxes the operand nibble by the counter.

Test Plan:
- WIDTH=16, add 0x1234 + 0x0FCD, out_ready=1 -> out_valid 4 cycles after accept; result 0x2201, cout 0, ovf 0, zero 0.
- Subtract 0x0005 - 0x0007 -> result 0xFFFE, cout 0 (borrow), ovf 0. Subtract 0x8000 - 0x0001 -> result 0x7FFF, cout 1, ovf 1.
- Add 0x7FFF + 0x0001 -> 0x8000, ovf 1, cout 0. Add 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0, zero 1.
- Backpressure: out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0. A second in_valid pulse is not accepted until the cycle after the out handshake, then completes correctly.
- Reset: rst_n low for one cycle during EXEC (counter = 2) -> all outputs at reset values immediately, in_ready 1, no out_valid for the aborted request. The next request completes normally.
- WIDTH=4 instance: 0x9 - 0x3 -> out_valid 1 cycle after accept; result 0x6, cout 1, ovf 1 (-7 - 3 overflows).

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer and its 4-bit slice.
package addsub_pkg;

    localparam int SLICE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit add/subtract slice; B is inverted internally when sub=1.
module nibble_addsub_slice
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               sub,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] b_x;
    logic [SLICE_W-1:0] low_sum;
    logic [1:0]         top_sum;

    assign b_x = b ^ {SLICE_W{sub}};

    // Split at the MSB so the carry into bit 3 is visible for overflow detection.
    assign low_sum = {1'b0, a[SLICE_W-2:0]} + {1'b0, b_x[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
    assign c_msb   = low_sum[SLICE_W-1];
    assign top_sum = {1'b0, a[SLICE_W-1]} + {1'b0, b_x[SLICE_W-1]} + {1'b0, c_msb};

    assign s    = {top_sum[0], low_sum[SLICE_W-2:0]};
    assign cout = top_sum[1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Sequences a WIDTH-bit add/sub through one 4-bit slice, LSB nibble first,
// with valid/ready handshakes on both the request and the result side.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam int NIB = WIDTH / SLICE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              sub_r;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [WIDTH-1:0]  acc, acc_nx;

    logic [SLICE_W-1:0] a_n, b_n, s;
    logic               c_out, c_msb;
    logic               last;

    assign a_n  = a_r[int'(cnt)*SLICE_W +: SLICE_W];
    assign b_n  = b_r[int'(cnt)*SLICE_W +: SLICE_W];
    assign last = (cnt == CW'(NIB - 1));

    nibble_addsub_slice u_slice (
        .a     (a_n),
        .b     (b_n),
        .sub   (sub_r),
        .cin   (carry),
        .s     (s),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // Full result including the nibble being written this cycle; used for the
    // final capture so out_zero sees the complete word.
    always_comb begin
        acc_nx = acc;
        acc_nx[int'(cnt)*SLICE_W +: SLICE_W] = s;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = EXEC;
            EXEC:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            carry      <= 1'b0;
            sub_r      <= OP_ADD;
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        sub_r <= in_sub;
                        carry <= in_sub;
                        cnt   <= '0;
                    end
                end
                EXEC: begin
                    acc   <= acc_nx;
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out_valid  <= 1'b1;
                        out_result <= acc_nx;
                        out_cout   <= c_out;
                        out_ovf    <= c_msb ^ c_out;
                        out_zero   <= (acc_nx == '0);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop and compare.
module tb_nibble_serial_addsub;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // 16-bit instance
    logic        v16, r16, s16, ov16, or16, co16, of16, z16, b16;
    logic [15:0] a16, bb16, res16;
    // 4-bit instance
    logic        v4, r4, s4, ov4, or4, co4, of4, z4, b4;
    logic [3:0]  a4, bb4, res4;

    nibble_serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(bb16),
        .in_sub(s16), .out_valid(ov16), .out_ready(or16), .out_result(res16),
        .out_cout(co16), .out_ovf(of16), .out_zero(z16), .busy(b16)
    );

    nibble_serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(bb4),
        .in_sub(s4), .out_valid(ov4), .out_ready(or4), .out_result(res4),
        .out_cout(co4), .out_ovf(of4), .out_zero(z4), .busy(b4)
    );

    exp_t q16[$];
    exp_t q4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    logic pv16 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov16 && !pv16) begin
                if (q16.size() == 0) chk("w16_unexpected_valid", 1, 0);
                else chk("w16_latency", cyc - q16[0].acc, 4);
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) chk("w16_unexpected_result", 1, 0);
                else begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("w16_result", res16, e.res);
                    chk("w16_cout", co16, e.cout);
                    chk("w16_ovf", of16, e.ovf);
                    chk("w16_zero", z16, e.zero);
                end
            end
        end
        pv16 <= rst_n ? ov16 : 1'b0;
    end

    logic pv4 = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov4 && !pv4) begin
                if (q4.size() == 0) chk("w4_unexpected_valid", 1, 0);
                else chk("w4_latency", cyc - q4[0].acc, 1);
            end
            if (ov4 && or4) begin
                if (q4.size() == 0) chk("w4_unexpected_result", 1, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("w4_result", {28'd0, res4}, {16'd0, e.res});
                    chk("w4_cout", co4, e.cout);
                    chk("w4_ovf", of4, e.ovf);
                    chk("w4_zero", z4, e.zero);
                end
            end
        end
        pv4 <= rst_n ? ov4 : 1'b0;
    end

    // ---------------- stimulus ----------------
    // Drives a request from a negedge and holds it until accepted; returns accept cycle.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                           input bit push, output int acc);
        exp_t e;
        bit done = 0;
        acc = -1;
        @(negedge clk);
        v16 = 1'b1; a16 = a; bb16 = b; s16 = sub;
        for (int i = 0; i < 50 && !done; i++) begin
            if (r16) begin
                @(posedge clk); #1;
                acc = cyc;
                e.res = er; e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = acc;
                if (push) q16.push_back(e);
                v16 = 1'b0;
                done = 1;
            end else @(negedge clk);
        end
        if (!done) begin
            chk("w16_accept_timeout", 0, 1);
            v16 = 1'b0;
        end
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                          input logic [3:0] er, input logic ec, input logic eo, input logic ez);
        exp_t e;
        bit done = 0;
        @(negedge clk);
        v4 = 1'b1; a4 = a; bb4 = b; s4 = sub;
        for (int i = 0; i < 50 && !done; i++) begin
            if (r4) begin
                @(posedge clk); #1;
                e.res = {12'd0, er}; e.cout = ec; e.ovf = eo; e.zero = ez; e.acc = cyc;
                q4.push_back(e);
                v4 = 1'b0;
                done = 1;
            end else @(negedge clk);
        end
        if (!done) begin
            chk("w4_accept_timeout", 0, 1);
            v4 = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (q16.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        if (q16.size() != 0 || q4.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    int acc_a, acc_b, hs_cyc;

    initial begin
        v16 = 0; a16 = 0; bb16 = 0; s16 = 0; or16 = 1;
        v4 = 0; a4 = 0; bb4 = 0; s4 = 0; or4 = 1;

        #2;
        chk("rst_out_valid", ov16, 0);
        chk("rst_out_result", res16, 0);
        chk("rst_flags", {co16, of16, z16}, 3'b000);
        chk("rst_busy", b16, 0);
        chk("rst_in_ready", r16, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        issue16(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 0, 0, 0, 1, acc_a);
        drain(20);
        issue16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 0, 0, 0, 1, acc_a);
        issue16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 1, 0, 1, acc_a);
        issue16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1, acc_a);
        issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 1, acc_a);
        drain(20);

        // Backpressure: first result held while a second request waits.
        or16 = 1'b0;
        issue16(16'h00FF, 16'h0101, 1'b0, 16'h0200, 0, 0, 0, 1, acc_a);
        for (int i = 0; i < 20 && !ov16; i++) @(negedge clk);
        chk("bp_valid_seen", ov16, 1);
        v16 = 1'b1; a16 = 16'h1000; bb16 = 16'h0001; s16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", res16, 16'h0200);
            chk("bp_hold_flags", {co16, of16, z16}, 3'b000);
            chk("bp_in_ready", r16, 0);
            chk("bp_valid_held", ov16, 1);
        end
        or16 = 1'b1;
        hs_cyc = cyc + 1;
        issue16(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1, 0, 0, 1, acc_b);
        chk("bp_accept_cycle", acc_b, hs_cyc + 1);
        drain(20);

        // Reset during EXEC with counter at 2 aborts the operation.
        issue16(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 0, 0, 0, 0, acc_a);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", ov16, 0);
        chk("abort_out_result", res16, 0);
        chk("abort_flags", {co16, of16, z16}, 3'b000);
        chk("abort_busy", b16, 0);
        chk("abort_in_ready", r16, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("abort_no_valid", ov16, 0);
        issue16(16'h4321, 16'h1234, 1'b1, 16'h30ED, 1, 0, 0, 1, acc_a);
        drain(20);

        // 4-bit instance
        issue4(4'h9, 4'h3, 1'b1, 4'h6, 1, 1, 0);
        issue4(4'h7, 4'h1, 1'b0, 4'h8, 0, 1, 0);
        issue4(4'h5, 4'h5, 1'b1, 4'h0, 1, 0, 1);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
